tinker_muldiv_unit: RTL and testbench



---
 rtl/tinker_muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_tinker_muldiv_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tinker_muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one bit per cycle.
// Optional build macro TINKER_MULDIV_EARLY_OUT_EN lets MUL finish once the multiplier is exhausted.
module tinker_muldiv_unit #(
    parameter int         WIDTH   = 64,
    parameter int         TAG_W   = 5,
    parameter logic [4:0] MUL_OPC = 5'h1c,
    parameter logic [4:0] DIV_OPC = 5'h1d
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_opcode,
    input  logic [WIDTH-1:0] req_op1,
    input  logic [WIDTH-1:0] req_op2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_dbz,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef TINKER_MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // acc: product accumulator (MUL) or partial remainder (DIV)
    logic [WIDTH-1:0]   acc_q, acc_d;
    // opa: shifting multiplicand (MUL) or dividend/quotient (DIV); opb: multiplier or divisor
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   mul_sum;
    logic [WIDTH-1:0]   mplier_nx;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic               div_ge;
    logic [CNT_W-1:0]   cnt_dec;
    logic [WIDTH-1:0]   quo_nx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        tag_d   = tag_q;
        dbz_d   = dbz_q;

        mul_sum   = acc_q + (opb_q[0] ? opa_q : '0);
        mplier_nx = opb_q >> 1;
        // Remainder kept one bit wider so the compare never loses the shifted-out MSB
        rem_sh    = {acc_q, opa_q[WIDTH-1]};
        div_ge    = (rem_sh >= {1'b0, opb_q});
        rem_sub   = rem_sh[WIDTH-1:0] - opb_q;
        quo_nx    = {opa_q[WIDTH-2:0], div_ge};
        cnt_dec   = cnt_q - 1'b1;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    acc_d = '0;
                    opa_d = req_op1;
                    opb_d = req_op2;
                    tag_d = req_tag;
                    cnt_d = CNT_W'(WIDTH);
                    if (req_opcode == MUL_OPC) begin
                        state_d = S_MUL;
                    end else if (req_opcode == DIV_OPC) begin
                        if (req_op2 != '0) begin
                            state_d = S_DIV;
                        end else begin
                            state_d = S_DONE;
                            res_d   = '1;
                            dbz_d   = 1'b1;
                        end
                    end else begin
                        state_d = S_DONE;
                        res_d   = '0;
                        dbz_d   = 1'b0;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_sum;
                opa_d = opa_q << 1;
                opb_d = mplier_nx;
                cnt_d = cnt_dec;
                if (cnt_dec == '0 || (EARLY_OUT && mplier_nx == '0)) begin
                    state_d = S_DONE;
                    res_d   = mul_sum;
                    dbz_d   = 1'b0;
                end
            end
            S_DIV: begin
                acc_d = div_ge ? rem_sub : rem_sh[WIDTH-1:0];
                opa_d = quo_nx;
                cnt_d = cnt_dec;
                if (cnt_dec == '0) begin
                    state_d = S_DONE;
                    res_d   = quo_nx;
                    dbz_d   = 1'b0;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            tag_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
            dbz_q   <= dbz_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign resp_result = res_q;
    assign resp_tag    = tag_q;
    assign resp_dbz    = dbz_q;

endmodule

// File: tb/tb_tinker_muldiv_unit.sv
// Randomized self-checking bench for tinker_muldiv_unit: 64-bit and 8-bit instances
// compared against a plain-arithmetic reference model.
module tb_tinker_muldiv_unit;

    localparam logic [4:0] MUL = 5'h1c;
    localparam logic [4:0] DIV = 5'h1d;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_v, resp_rdy, sel8;
    logic [4:0]  req_opc;
    logic [63:0] req_a, req_b;
    logic [4:0]  req_t;

    logic        rv64, rr64, rdy64, vld64, dbz64, busy64;
    logic [63:0] res64;
    logic [4:0]  tag64;
    logic        rv8, rr8, rdy8, vld8, dbz8, busy8;
    logic [7:0]  res8, a8, b8;
    logic [4:0]  tag8;

    logic        o_rdy, o_vld, o_dbz, o_busy;
    logic [63:0] o_res;
    logic [4:0]  o_tag;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign rv64 = req_v & ~sel8;
    assign rv8  = req_v & sel8;
    assign rr64 = resp_rdy & ~sel8;
    assign rr8  = resp_rdy & sel8;
    assign a8   = req_a[7:0];
    assign b8   = req_b[7:0];

    tinker_muldiv_unit #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .req_valid(rv64), .req_ready(rdy64),
        .req_opcode(req_opc), .req_op1(req_a), .req_op2(req_b), .req_tag(req_t),
        .resp_valid(vld64), .resp_ready(rr64), .resp_result(res64),
        .resp_tag(tag64), .resp_dbz(dbz64), .busy(busy64)
    );

    tinker_muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .req_valid(rv8), .req_ready(rdy8),
        .req_opcode(req_opc), .req_op1(a8), .req_op2(b8), .req_tag(req_t),
        .resp_valid(vld8), .resp_ready(rr8), .resp_result(res8),
        .resp_tag(tag8), .resp_dbz(dbz8), .busy(busy8)
    );

    always_comb begin
        o_rdy  = rdy64;
        o_vld  = vld64;
        o_dbz  = dbz64;
        o_busy = busy64;
        o_res  = res64;
        o_tag  = tag64;
        if (sel8) begin
            o_rdy  = rdy8;
            o_vld  = vld8;
            o_dbz  = dbz8;
            o_busy = busy8;
            o_res  = {56'd0, res8};
            o_tag  = tag8;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: what the operation means arithmetically
    function automatic logic [63:0] ref_result(input int w, input logic [4:0] opc,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m = wmask(w);
        logic [63:0] x = a & m;
        logic [63:0] y = b & m;
        if (opc == MUL) return (x * y) & m;
        if (opc == DIV) return (y == 0) ? m : (x / y);
        return 64'd0;
    endfunction

    // Edges from accept until resp_valid is first seen
    function automatic int ref_latency(input int w, input logic [4:0] opc, input logic [63:0] b);
        logic [63:0] y = b & wmask(w);
        int k = 0;
        if (opc == DIV) return (y == 0) ? 1 : w + 1;
        if (opc != MUL) return 1;
`ifdef TINKER_MULDIV_EARLY_OUT_EN
        for (int i = 0; i < w; i++) if (y[i]) k = i;
        return k + 2;
`else
        k = w;
        return k + 1;
`endif
    endfunction

    task automatic do_op(input logic s8, input logic [4:0] opc, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] t);
        int w = s8 ? 8 : 64;
        int j = 0;
        sel8    = s8;
        req_opc = opc;
        req_a   = a;
        req_b   = b;
        req_t   = t;
        req_v   = 1'b1;
        #0;
        check_val("req_ready_idle", {63'd0, o_rdy}, 64'd1);
        @(posedge clk); #1;
        req_v = 1'b0;
        check_val("busy_after_accept", {63'd0, o_busy}, 64'd1);
        while (!o_vld && j < 200) begin
            @(posedge clk); #1;
            j++;
        end
        check_val("latency", 64'(j + 1), 64'(ref_latency(w, opc, b)));
        check_val("result", o_res, ref_result(w, opc, a, b));
        check_val("tag", {59'd0, o_tag}, {59'd0, t});
        check_val("dbz", {63'd0, o_dbz}, {63'd0, (opc == DIV && (b & wmask(w)) == 0)});
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        check_val("valid_after_hs", {63'd0, o_vld}, 64'd0);
        check_val("ready_after_hs", {63'd0, o_rdy}, 64'd1);
    endtask

    task automatic rand_op(input logic s8);
        logic [4:0]  opc;
        logic [63:0] a, b;
        int sel = $urandom_range(0, 9);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        if (sel < 4)       opc = MUL;
        else if (sel < 8)  opc = DIV;
        else if (sel == 8) opc = 5'h18;
        else               opc = 5'($urandom);
        case ($urandom_range(0, 5))
            0: b = 64'd0;
            1: b = b >> $urandom_range(0, 63);
            2: b = 64'd1;
            default: ;
        endcase
        do_op(s8, opc, a, b, 5'($urandom));
    endtask

    initial begin
        int seen;
        reset = 1'b1; req_v = 1'b0; resp_rdy = 1'b0; sel8 = 1'b0;
        req_opc = '0; req_a = '0; req_b = '0; req_t = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("rst_req_ready", {63'd0, rdy64}, 64'd1);
        check_val("rst_resp_valid", {63'd0, vld64}, 64'd0);
        check_val("rst_busy", {63'd0, busy64}, 64'd0);
        check_val("rst_result", res64, 64'd0);
        check_val("rst_tag", {59'd0, tag64}, 64'd0);
        check_val("rst_dbz", {63'd0, dbz64}, 64'd0);

        do_op(1'b0, MUL, 64'd7, 64'd6, 5'd3);
        do_op(1'b0, DIV, 64'd100, 64'd7, 5'd9);
        do_op(1'b0, DIV, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd4);
        do_op(1'b0, DIV, 64'd5, 64'd0, 5'd2);
        do_op(1'b0, DIV, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 5'd6);
        do_op(1'b0, MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31);
        do_op(1'b0, MUL, 64'd123, 64'd0, 5'd1);

        // Backpressure with an ignored request during DONE
        sel8 = 1'b0; req_opc = MUL; req_a = 64'd3; req_b = 64'd4; req_t = 5'd12; req_v = 1'b1;
        @(posedge clk); #1;
        req_v = 1'b0;
        seen = 0;
        while (!vld64 && seen < 200) begin @(posedge clk); #1; seen++; end
        req_opc = DIV; req_a = 64'd99; req_b = 64'd3; req_t = 5'd7; req_v = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_val("bp_valid", {63'd0, vld64}, 64'd1);
            check_val("bp_result", res64, 64'd12);
            check_val("bp_req_ready", {63'd0, rdy64}, 64'd0);
            @(posedge clk); #1;
        end
        req_v = 1'b0;
        check_val("bp_tag", {59'd0, tag64}, 64'd12);
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        check_val("bp_release_ready", {63'd0, rdy64}, 64'd1);
        check_val("bp_release_valid", {63'd0, vld64}, 64'd0);
        check_val("bp_result_held", res64, 64'd12);

        // Reset in the middle of a multiply
        req_opc = MUL; req_a = 64'd9; req_b = 64'hFFFF; req_t = 5'd5; req_v = 1'b1;
        @(posedge clk); #1;
        req_v = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("mid_busy_before", {63'd0, busy64}, 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("mid_rst_busy", {63'd0, busy64}, 64'd0);
        check_val("mid_rst_ready", {63'd0, rdy64}, 64'd1);
        check_val("mid_rst_result", res64, 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (vld64) seen++;
            @(posedge clk); #1;
        end
        check_val("mid_rst_no_resp", 64'(seen), 64'd0);

        // Narrow instance
        do_op(1'b1, MUL, 64'h10, 64'h20, 5'd8);
        do_op(1'b1, 5'h18, 64'h33, 64'h44, 5'd17);
        do_op(1'b1, DIV, 64'hFF, 64'h81, 5'd10);
        do_op(1'b1, DIV, 64'h07, 64'h00, 5'd11);

        for (int i = 0; i < 20; i++) rand_op(1'b0);
        for (int i = 0; i < 30; i++) rand_op(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
